demux_dispatcher: RTL
=====================

Name: demux_dispatcher

Overview:
- Packet-level controller that steers one valid/ready input stream to one of N_OUT consumer streams, i.e. a sequenced, multi-way generalisation of the 1-bit demultiplexer.
- Port selection is made once per packet, either fixed from `cfg_sel` or round-robin, and is held until the last beat is accepted.
- Keeps a saturating per-port packet count and a drop count for invalid selections.
- Sits between a single producer and N_OUT parallel consumers.

Parameters:
- N_OUT, 4, number of output ports (2..16).
- DATA_W, 8, data beat width.
- CNT_W, 16, width of each packet counter.
- SEL_W, $clog2(N_OUT) (minimum 1), port index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_mode  in  1  0 = fixed (use `cfg_sel`), 1 = round-robin.
- cfg_sel  in  SEL_W  target port in fixed mode.
- s_valid  in  1  input beat valid.
- s_data  in  DATA_W  input beat data.
- s_last  in  1  input beat is last of packet.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- m_valid  out  N_OUT  per-port beat valid, at most one bit set.
- m_data  out  DATA_W  broadcast data, equal to `s_data`.
- m_last  out  1  broadcast last, equal to `s_last`.
- m_ready  in  N_OUT  per-port consumer ready.
- busy  out  1  high in BUSY or DROP.
- cur_port  out  SEL_W  port currently locked; 0 when idle.
- pkt_cnt  out  N_OUT*CNT_W  packets completed per port; port p occupies bits [p*CNT_W +: CNT_W].
- drop_cnt  out  CNT_W  packets dropped.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, cur_port=0, all counters 0.
  - Outputs: m_valid=0, s_ready=0, busy=0.
  - Reset mid-packet abandons the packet with no count update. Remaining upstream beats are then treated as the start of a new packet.
- States: IDLE, BUSY, DROP.
- IDLE:
  - s_ready=0, m_valid=0.
  - If s_valid=1, sample the target at this edge: fixed mode uses p=cfg_sel; round-robin uses p=rr_ptr.
  - p < N_OUT -> BUSY, cur_port=p. Otherwise (fixed mode, cfg_sel>=N_OUT) -> DROP.
  - This costs exactly one idle bubble cycle per packet, before the first beat.
- BUSY:
  - Combinational routing: m_valid[cur_port]=s_valid, all other m_valid bits 0, s_ready=m_ready[cur_port].
  - Zero-cycle latency through the block.
  - Beat accepted when s_valid && m_ready[cur_port]. Ready on any non-selected port is ignored.
  - Accepted beat with s_last=1:
    - next state=IDLE;
    - pkt_cnt[cur_port] += 1, saturating at 2^CNT_W-1;
    - in round-robin mode, rr_ptr=(cur_port+1) mod N_OUT, wrapping N_OUT-1 -> 0.
  - Fixed mode leaves rr_ptr unchanged.
- DROP:
  - s_ready=1, m_valid=0.
  - Accepted beat with s_last=1 -> IDLE, drop_cnt += 1 (saturating).
- cfg_mode and cfg_sel are sampled only in IDLE. Changes during BUSY or DROP have no effect on the current packet.
- Single-beat packet: IDLE (1 cycle) then BUSY; completion occurs on the first handshake.
- Back-to-back packets: a minimum of one IDLE cycle between the last beat and the next first beat.
- Consumer stalls (m_ready=0) hold the block in BUSY indefinitely; there is no timeout.
- s_valid may drop mid-packet: m_valid follows it and the state is held.
- busy=(state!=IDLE). cur_port returns to 0 on entry to IDLE.

Decomposition:
- Package demux_dispatcher_pkg:
  - state enum (IDLE, BUSY, DROP);
  - mode constants MODE_FIXED=0, MODE_RR=1.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count): one instance per port plus one for drops.
- Next-port and wrap logic stays inline.

Test Plan:
- Fixed mode, cfg_sel=2, all m_ready=1, 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3):
  - 1 bubble cycle, then m_valid=4'b0100 for 3 cycles with m_data matching each beat;
  - then pkt_cnt[2]=1, busy=0.
- Round-robin, 5 single-beat packets back-to-back:
  - ports 0,1,2,3,0 in order, each preceded by 1 idle cycle;
  - final pkt_cnt={1,1,1,2} for ports {3,2,1,0}, i.e. port 0 has 2.
- Backpressure: port 1 locked, m_ready[1]=0 for 4 cycles while m_ready[0]=1:
  - s_ready=0 throughout and no beat accepted;
  - when m_ready[1]=1 the beat transfers the same cycle.
- N_OUT=3 instance, fixed mode, cfg_sel=3, 2-beat packet:
  - s_ready=1 in DROP, m_valid=0;
  - drop_cnt=1, all pkt_cnt=0.
- rst asserted during beat 2 of 4 on port 1:
  - next cycle state=IDLE, m_valid=0, s_ready=0, pkt_cnt[1]=0, rr_ptr=0.
- CNT_W=2, 5 packets to port 0:
  - pkt_cnt[0] saturates at 3 and stays 3.

Source files
------------

// File: rtl/demux_dispatcher_pkg.sv
// rtl/demux_dispatcher_pkg.sv - shared types and constants for the packet demux dispatcher
package demux_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, clears on synchronous reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Increment on request, but hold once the all-ones ceiling is reached.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - steers one packet stream to one of N_OUT consumers, per-packet port lock
module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_mode,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [N_OUT-1:0]       m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_last,
  input  logic [N_OUT-1:0]       m_ready,
  output logic                   busy,
  output logic [SEL_W-1:0]       cur_port,
  output logic [N_OUT*CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_port_q, cur_port_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] sel_p;
  logic [N_OUT-1:0] pkt_inc;
  logic             drop_inc;

  // Candidate port for the next packet; only consulted while idle.
  assign sel_p = (cfg_mode == MODE_RR) ? rr_ptr_q : cfg_sel;

  // Next-state, routing and counter strobes. The packet's mode is latched at
  // lock time so a mid-packet cfg_mode change cannot alter the rr_ptr update.
  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    rr_ptr_d   = rr_ptr_q;
    mode_d     = mode_q;
    m_valid    = '0;
    s_ready    = 1'b0;
    pkt_inc    = '0;
    drop_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          mode_d = cfg_mode;
          if (int'(sel_p) < N_OUT) begin
            state_d    = BUSY;
            cur_port_d = sel_p;
          end else begin
            state_d = DROP;
          end
        end
      end
      BUSY: begin
        m_valid[cur_port_q] = s_valid;
        s_ready             = m_ready[cur_port_q];
        if (s_valid && m_ready[cur_port_q] && s_last) begin
          state_d             = IDLE;
          cur_port_d          = '0;
          pkt_inc[cur_port_q] = 1'b1;
          if (mode_q == MODE_RR) begin
            rr_ptr_d = (int'(cur_port_q) == N_OUT - 1) ? '0 : cur_port_q + SEL_W'(1);
          end
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        cur_port_d = '0;
      end
    endcase
  end

  // Control registers; reset abandons any packet in flight without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_port_q <= '0;
      rr_ptr_q   <= '0;
      mode_q     <= MODE_FIXED;
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      rr_ptr_q   <= rr_ptr_d;
      mode_q     <= mode_d;
    end
  end

  for (genvar p = 0; p < N_OUT; p++) begin : g_pkt
    sat_counter #(.W(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pkt_inc[p]),
      .count (pkt_cnt[p*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  assign m_data   = s_data;
  assign m_last   = s_last;
  assign busy     = (state_q != IDLE);
  assign cur_port = cur_port_q;

endmodule
